auto_play_seq: RTL and testbench

Parametrised melody sequencer that replaces the fixed single-song auto-player. It steps through a song table held in an external synchronous ROM at a programmable tempo. It supports multiple songs, loop or one-shot mode, and play/pause/stop control. Its output is a note index (0 = rest) that feeds the tone generator exactly as the manual-play key index does.

---
 rtl/auto_play_seq.sv | 154 +++++++++++++++
 tb/tb_auto_play_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_play_seq.sv
// Melody sequencer: walks a song table in an external synchronous ROM at a
// selectable tempo, producing a note index (0 = rest) for the tone generator.
module auto_play_seq #(
    parameter int STEP_DIV = 625000,
    parameter int DIV_W    = 21,
    parameter int LEN      = 96,
    parameter int STEP_W   = 7,
    parameter int SONGS    = 2,
    parameter int SONG_W   = 1,
    parameter int IDX_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      pause,
    input  logic                      loop_en,
    input  logic [SONG_W-1:0]         song_sel,
    input  logic [1:0]                tempo_sel,
    output logic [SONG_W+STEP_W-1:0]  rom_addr,
    output logic                      rom_en,
    input  logic [IDX_W-1:0]          rom_data,
    output logic [IDX_W-1:0]          note_idx,
    output logic                      note_strobe,
    output logic [STEP_W-1:0]         step_pos,
    output logic                      playing,
    output logic                      paused,
    output logic                      done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        PLAY  = 3'd3,
        PAUSE = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SONG_W-1:0]   song_q;
    logic [1:0]          tempo_q;
    logic [STEP_W-1:0]   step;
    logic [DIV_W-1:0]    presc;
    logic [IDX_W-1:0]    note_q;
    logic [DIV_W-1:0]    div_eff;
    logic                tc;
    logic                last_step;

    // Step length in clocks for a tempo code, never shorter than the
    // 4-cycle fetch/wait/play minimum.
    function automatic logic [DIV_W-1:0] eff_div(input logic [1:0] t);
        int d;
        case (t)
            2'b01:   d = STEP_DIV >> 1;
            2'b10:   d = STEP_DIV << 1;
            default: d = STEP_DIV;
        endcase
        if (d < 4) d = 4;
        return DIV_W'(d);
    endfunction

    assign div_eff   = eff_div(tempo_q);
    assign tc        = (state == PLAY) && (presc == div_eff - DIV_W'(1));
    assign last_step = (step == STEP_W'(LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                FETCH: state_nxt = WAIT;
                WAIT:  state_nxt = PLAY;
                // A step boundary takes precedence over a pause request.
                PLAY: begin
                    if (tc)         state_nxt = (last_step && !loop_en) ? IDLE : FETCH;
                    else if (pause) state_nxt = PAUSE;
                end
                PAUSE: if (!pause) state_nxt = PLAY;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rom_en   = (state == FETCH);
        rom_addr = {song_q, step};
        playing  = (state != IDLE);
        paused   = (state == PAUSE);
        note_idx = (state == PAUSE) ? '0 : note_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            song_q      <= '0;
            tempo_q     <= '0;
            step        <= '0;
            presc       <= '0;
            note_q      <= '0;
            step_pos    <= '0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                note_q <= '0;
                presc  <= '0;
            end else if (start) begin
                song_q  <= (int'(song_sel) < SONGS) ? song_sel : '0;
                tempo_q <= tempo_sel;
                step    <= '0;
                presc   <= '0;
            end else begin
                case (state)
                    FETCH: presc <= presc + DIV_W'(1);
                    WAIT: begin
                        presc       <= presc + DIV_W'(1);
                        note_q      <= rom_data;
                        step_pos    <= step;
                        note_strobe <= 1'b1;
                    end
                    PLAY: begin
                        if (tc) begin
                            presc   <= '0;
                            tempo_q <= tempo_sel;
                            if (!last_step) begin
                                step <= step + STEP_W'(1);
                            end else if (loop_en) begin
                                step <= '0;
                            end else begin
                                note_q <= '0;
                                done   <= 1'b1;
                            end
                        end else begin
                            presc <= presc + DIV_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_auto_play_seq.sv
// Scoreboard bench for auto_play_seq with STEP_DIV=8, LEN=4 and a two-song ROM.
module tb_auto_play_seq;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, loop_en;
    logic [0:0] song_sel;
    logic [1:0] tempo_sel;
    logic [2:0] rom_addr;
    logic       rom_en;
    logic [4:0] rom_data;
    logic [4:0] note_idx;
    logic       note_strobe;
    logic [1:0] step_pos;
    logic       playing, paused, done;

    auto_play_seq #(
        .STEP_DIV(8), .DIV_W(5), .LEN(4), .STEP_W(2),
        .SONGS(2), .SONG_W(1), .IDX_W(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .song_sel(song_sel), .tempo_sel(tempo_sel),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .note_idx(note_idx), .note_strobe(note_strobe), .step_pos(step_pos),
        .playing(playing), .paused(paused), .done(done)
    );

    always #5 clk = ~clk;

    logic [4:0] rom [8];
    logic [4:0] rom_q = '0;
    initial begin
        rom[0] = 5'd3; rom[1] = 5'd0; rom[2] = 5'd5; rom[3] = 5'd7;
        rom[4] = 5'd1; rom[5] = 5'd2; rom[6] = 5'd4; rom[7] = 5'd6;
    end
    always @(posedge clk) if (rom_en) rom_q <= rom[rom_addr];
    assign rom_data = rom_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int note; int step; int cyc; } exp_t;
    exp_t sq[$];
    int   dq[$];
    int   aq[$];
    bit   rom_chk = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every strobe, done pulse and (when enabled) ROM fetch.
    always @(negedge clk) begin
        exp_t e;
        int   x;
        if (note_strobe === 1'b1) begin
            if (sq.size() == 0) chk("stray_strobe", int'(note_strobe), 0);
            else begin
                e = sq.pop_front();
                chk("note", int'(note_idx), e.note);
                chk("step", int'(step_pos), e.step);
                chk("strobe_cyc", cyc, e.cyc);
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) chk("stray_done", int'(done), 0);
            else begin
                x = dq.pop_front();
                chk("done_cyc", cyc, x);
            end
        end
        if (rom_chk && rom_en === 1'b1) begin
            if (aq.size() == 0) chk("stray_fetch", int'(rom_addr), -1);
            else begin
                x = aq.pop_front();
                chk("rom_addr", int'(rom_addr), x);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push_note(input int n, input int s, input int c);
        exp_t e;
        e.note = n; e.step = s; e.cyc = c;
        sq.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_pending_notes"}, sq.size(), 0);
        chk({tag, "_pending_done"}, dq.size(), 0);
        chk({tag, "_pending_fetch"}, aq.size(), 0);
        sq.delete(); dq.delete(); aq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int c2;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        loop_en = 1'b0; song_sel = '0; tempo_sel = 2'b00;
        repeat (3) tick();
        chk("rst_note", int'(note_idx), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        rst = 1'b0;
        tick();

        // One-shot song 0: strobes every 8 cycles, done one step after note 7's fetch.
        c = cyc;
        push_note(3, 0, c + 3); push_note(0, 1, c + 11);
        push_note(5, 2, c + 19); push_note(7, 3, c + 27);
        dq.push_back(c + 33);
        pulse_start();
        wait_until(c + 35);
        chk("oneshot_note_end", int'(note_idx), 0);
        chk("oneshot_playing", int'(playing), 0);
        queues_empty("oneshot");

        // Looping song 1 with ROM address tracking.
        loop_en = 1'b1; song_sel = 1'b1;
        c = cyc;
        push_note(1, 0, c + 3);  push_note(2, 1, c + 11);
        push_note(4, 2, c + 19); push_note(6, 3, c + 27);
        push_note(1, 0, c + 35); push_note(2, 1, c + 43);
        aq.push_back(4); aq.push_back(5); aq.push_back(6);
        aq.push_back(7); aq.push_back(4); aq.push_back(5);
        rom_chk = 1'b1;
        pulse_start();
        wait_until(c + 44);
        pulse_stop();
        rom_chk = 1'b0;
        chk("loop_stop_playing", int'(playing), 0);
        queues_empty("loop");

        // Runtime tempo changes: x2 then x0.5, each from the following step.
        song_sel = 1'b0;
        c = cyc;
        push_note(3, 0, c + 3);  push_note(0, 1, c + 11);
        push_note(5, 2, c + 15); push_note(7, 3, c + 19);
        push_note(3, 0, c + 23); push_note(0, 1, c + 39);
        push_note(5, 2, c + 55);
        pulse_start();
        wait_until(c + 5);
        tempo_sel = 2'b01;
        wait_until(c + 18);
        tempo_sel = 2'b10;
        wait_until(c + 56);
        pulse_stop();
        tempo_sel = 2'b00;
        queues_empty("tempo");

        // Pause for 10 cycles starting 3 cycles into note 5.
        loop_en = 1'b0;
        c = cyc;
        push_note(3, 0, c + 3);  push_note(0, 1, c + 11);
        push_note(5, 2, c + 19); push_note(7, 3, c + 37);
        dq.push_back(c + 43);
        pulse_start();
        wait_until(c + 21);
        pause = 1'b1;
        wait_until(c + 25);
        chk("pause_note", int'(note_idx), 0);
        chk("pause_flag", int'(paused), 1);
        chk("pause_playing", int'(playing), 1);
        wait_until(c + 31);
        pause = 1'b0;
        wait_until(c + 32);
        chk("resume_note", int'(note_idx), 5);
        chk("resume_flag", int'(paused), 0);
        chk("resume_strobe", int'(note_strobe), 0);
        wait_until(c + 45);
        queues_empty("pause");

        // Mid-song restart on song 1, then stop.
        loop_en = 1'b1;
        c = cyc;
        push_note(3, 0, c + 3); push_note(0, 1, c + 11);
        pulse_start();
        wait_until(c + 13);
        song_sel = 1'b1;
        c2 = cyc;
        push_note(1, 0, c2 + 3);
        pulse_start();
        song_sel = 1'b0;
        wait_until(c2 + 3);
        chk("restart_note", int'(note_idx), 1);
        chk("restart_step", int'(step_pos), 0);
        wait_until(c2 + 5);
        pulse_stop();
        chk("stop_note", int'(note_idx), 0);
        chk("stop_playing", int'(playing), 0);
        wait_until(c2 + 12);
        queues_empty("restart");

        // Reset while in WAIT, then reset together with start.
        song_sel = 1'b1;
        c = cyc;
        pulse_start();
        wait_until(c + 2);
        chk("wait_rom_addr", int'(rom_addr), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wrst_note", int'(note_idx), 0);
        chk("wrst_strobe", int'(note_strobe), 0);
        chk("wrst_step", int'(step_pos), 0);
        chk("wrst_rom_addr", int'(rom_addr), 0);
        chk("wrst_rom_en", int'(rom_en), 0);
        chk("wrst_playing", int'(playing), 0);
        chk("wrst_paused", int'(paused), 0);
        chk("wrst_done", int'(done), 0);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_playing", int'(playing), 0);
        tick(); tick();
        chk("rst_start_idle", int'(playing), 0);
        chk("rst_start_rom_en", int'(rom_en), 0);

        // Start and stop in the same cycle: stop wins.
        song_sel = 1'b0;
        c = cyc;
        push_note(3, 0, c + 3);
        pulse_start();
        wait_until(c + 5);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_playing", int'(playing), 0);
        chk("start_stop_note", int'(note_idx), 0);
        wait_until(c + 12);
        queues_empty("start_stop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
